// File: rtl/fp32_pkg.sv
// Shared binary32 constants and raw-mantissa field layout for the adder back end.
package fp32_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 5;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Raw mantissa layout: {carry, hidden, fraction, G, R, S}
    localparam int CARRY_POS  = MANT_W - 1;
    localparam int HIDDEN_POS = MANT_W - 2;
    localparam int G_POS      = 2;
    localparam int R_POS      = 1;
    localparam int S_POS      = 0;

    typedef enum logic [2:0] {
        K_NORM,
        K_ZERO,
        K_FLUSH,
        K_NAN,
        K_INF
    } kind_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = 5
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);

    logic found;

    always_comb begin
        cnt   = CW'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                cnt   = CW'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalize / round-to-nearest-even back end producing packed binary32
// with overflow, underflow and inexact flags; valid/ready on both sides.
module fp_normalize_round
    import fp32_pkg::*;
#(
    parameter int EXP_W  = fp32_pkg::EXP_W,
    parameter int FRAC_W = fp32_pkg::FRAC_W,
    parameter int MANT_W = FRAC_W + 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_nan,
    input  logic              in_inf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);

    localparam int NW = HIDDEN_POS + 1;   // bits below the carry
    localparam int FW = NW - 1;           // fraction plus G/R/S, hidden bit implied
    localparam int EW = EXP_W + 2;

    logic          s1_valid;
    logic          s1_sign;
    logic [EXP_W:0] s1_exp;
    logic [FW-1:0] s1_mant;
    kind_e         s1_kind;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- stage 1: normalize ----------------
    logic [4:0]           lzc;
    logic signed [EW-1:0] n_exp;
    logic [FW-1:0]        n_mant;
    kind_e                n_kind;

    fp_lzc #(.W(NW), .CW(5)) u_lzc (
        .d   (in_mant[NW-1:0]),
        .cnt (lzc)
    );

    always_comb begin
        n_exp  = '0;
        n_mant = '0;
        n_kind = K_NORM;
        if (in_nan) begin
            n_kind = K_NAN;
        end else if (in_inf) begin
            n_kind = K_INF;
        end else if (in_mant[CARRY_POS]) begin
            n_mant = {in_mant[HIDDEN_POS:S_POS+2], in_mant[S_POS+1] | in_mant[S_POS]};
            n_exp  = $signed({2'b00, in_exp}) + EW'(1);
        end else if (in_mant == '0) begin
            n_kind = K_ZERO;
        end else begin
            // The leading one lands on the hidden position, so only the bits below it matter.
            n_mant = in_mant[FW-1:0] << lzc;
            n_exp  = $signed({2'b00, in_exp}) - $signed({{(EW-5){1'b0}}, lzc});
        end
        if (n_kind == K_NORM && n_exp <= 0) begin
            n_kind = K_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_kind  <= K_ZERO;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= n_exp[EXP_W:0];
                s1_mant <= n_mant;
                s1_kind <= n_kind;
            end
        end
    end

    // ---------------- stage 2: round (RNE) ----------------
    logic              lsb, g_bit, r_bit, s_bit;
    logic              rnd_up;
    logic [FRAC_W:0]   frac_sum;
    logic [EW-1:0]     r_exp;
    logic [31:0]       r_result;
    logic              r_ov, r_uf, r_ix;

    assign lsb   = s1_mant[G_POS+1];
    assign g_bit = s1_mant[G_POS];
    assign r_bit = s1_mant[R_POS];
    assign s_bit = s1_mant[S_POS];

    always_comb begin
        rnd_up   = g_bit & (r_bit | s_bit | lsb);
        frac_sum = {1'b0, s1_mant[FW-1:G_POS+1]} + (FRAC_W+1)'(rnd_up);
        // Fraction wrap means 1.11..1 rounded to 2.0; the low bits are already zero.
        r_exp    = {1'b0, s1_exp} + EW'(frac_sum[FRAC_W]);
        r_result = '0;
        r_ov     = 1'b0;
        r_uf     = 1'b0;
        r_ix     = 1'b0;
        case (s1_kind)
            K_NAN:   r_result = QNAN;
            K_INF:   r_result = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            K_ZERO:  r_result = '0;
            K_FLUSH: begin
                r_result = {s1_sign, {(EXP_W + FRAC_W){1'b0}}};
                r_uf     = 1'b1;
                r_ix     = 1'b1;
            end
            default: begin
                if (r_exp >= EW'(EXP_MAX)) begin
                    r_result = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    r_ov     = 1'b1;
                    r_ix     = 1'b1;
                end else begin
                    r_result = {s1_sign, r_exp[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
                    r_ix     = g_bit | r_bit | s_bit;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= r_result;
                out_overflow  <= r_ov;
                out_underflow <= r_uf;
                out_inexact   <= r_ix;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: arithmetic cases, specials,
// backpressure ordering and asynchronous reset with beats in flight.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    // exp_out = {result, overflow, underflow, inexact}
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        nan;
        logic        inf;
        logic [34:0] exp_out;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want)
            $display("FAIL %s: got %h expected %h", tag, got, want);
        else
            passes++;
    endtask

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                                input logic n, input logic i, input logic [31:0] r,
                                input logic [2:0] f);
        return {s, e, m, n, i, r, f};
    endfunction

    function automatic logic [34:0] observed();
        return {out_result, out_overflow, out_underflow, out_inexact};
    endfunction

    task automatic drive(input vec_t v);
        in_sign = v.sign;
        in_exp  = v.exp;
        in_mant = v.mant;
        in_nan  = v.nan;
        in_inf  = v.inf;
    endtask

    task automatic run_vec(input int k);
        int  lat;
        logic seen;
        @(negedge clk);
        drive(vecs[k]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check($sformatf("vec%0d_latency", k), 64'(lat), 64'd2);
        check($sformatf("vec%0d_result", k), 64'(observed()), 64'(vecs[k].exp_out));
    endtask

    initial begin
        int          bp [4];
        int          idx;
        int          nout;
        int          stale;

        vecs[0]  = mk(0, 8'd131, {2'b01, 23'h440000, 3'b000}, 0, 0, 32'h41C40000, 3'b000);
        vecs[1]  = mk(0, 8'd127, {2'b10, 23'h000000, 3'b000}, 0, 0, 32'h40000000, 3'b000);
        vecs[2]  = mk(0, 8'd127, {2'b00, 23'h200000, 3'b000}, 0, 0, 32'h3E800000, 3'b000);
        vecs[3]  = mk(0, 8'd127, {2'b01, 23'h7FFFFF, 3'b100}, 0, 0, 32'h40000000, 3'b001);
        vecs[4]  = mk(0, 8'd127, {2'b01, 23'h7FFFFE, 3'b100}, 0, 0, 32'h3FFFFFFE, 3'b001);
        vecs[5]  = mk(0, 8'd254, {2'b10, 23'h000000, 3'b000}, 0, 0, 32'h7F800000, 3'b101);
        vecs[6]  = mk(0, 8'd5,   28'h1234567,                 1, 0, 32'h7FC00000, 3'b000);
        vecs[7]  = mk(1, 8'd3,   28'h0000000,                 0, 1, 32'hFF800000, 3'b000);
        vecs[8]  = mk(1, 8'd100, 28'h0000000,                 0, 0, 32'h00000000, 3'b000);
        vecs[9]  = mk(1, 8'd1,   {2'b00, 23'h200000, 3'b000}, 0, 0, 32'h80000000, 3'b011);
        vecs[10] = mk(0, 8'd127, 28'hC000001,                 0, 0, 32'h40400000, 3'b001);
        vecs[11] = mk(0, 8'd127, {2'b01, 23'h000001, 3'b110}, 0, 0, 32'h3F800002, 3'b001);
        vecs[12] = mk(1, 8'd9,   28'h0000000,                 1, 1, 32'h7FC00000, 3'b000);
        vecs[13] = mk(0, 8'd1,   {2'b00, 23'h400000, 3'b000}, 0, 0, 32'h00000000, 3'b011);
        vecs[14] = mk(0, 8'd2,   {2'b00, 23'h400000, 3'b000}, 0, 0, 32'h00800000, 3'b000);
        vecs[15] = mk(0, 8'd254, {2'b01, 23'h7FFFFF, 3'b000}, 0, 0, 32'h7F7FFFFF, 3'b000);
        vecs[16] = mk(0, 8'd254, {2'b01, 23'h7FFFFF, 3'b110}, 0, 0, 32'h7F800000, 3'b101);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'(observed()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // Backpressure: four beats back to back, consumer stalled for three cycles.
        bp   = '{0, 1, 2, 10};
        idx  = 0;
        nout = 0;
        for (int cyc = 1; cyc <= 30 && nout < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc > 3);
            in_valid  = (idx < 4);
            if (idx < 4) drive(vecs[bp[idx]]);
            #1;
            if (cyc == 3) begin
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_accepts", 64'(idx), 64'd2);
            end
            if (out_valid && !out_ready)
                check("bp_hold", 64'(observed()), 64'(vecs[bp[nout]].exp_out));
            if (out_valid && out_ready) begin
                check($sformatf("bp_out%0d", nout), 64'(observed()), 64'(vecs[bp[nout]].exp_out));
                nout++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        check("bp_count", 64'(nout), 64'd4);

        // Asynchronous reset with two beats in flight.
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("inflight_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_outputs", 64'(observed()), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_beat", 64'(stale), 64'd0);
        run_vec(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
